// File: rtl/cfg_reg_initiator.sv
// Command-driven requester for the DMAC configuration-register bus.
// Runs READ, WRITE and read-modify-write commands and returns one response per command.
module cfg_reg_initiator #(
  parameter int AW     = 4,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [31:0]   cmd_wdata_i,
  input  logic [31:0]   cmd_mask_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] reg_addr_o,
  output logic          reg_wren_o,
  output logic          reg_rden_o,
  output logic [31:0]   reg_wdata_o,
  input  logic [31:0]   reg_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RSP     = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [2:0] LAT_M1   = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  function automatic logic [31:0] rmw_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  state_t        state_r, state_nxt_s;
  logic [1:0]    op_r, op_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [31:0]   wdata_r, wdata_nxt_s;
  logic [31:0]   mask_r, mask_nxt_s;
  logic [31:0]   rd_r, rd_nxt_s;
  logic [2:0]    cnt_r, cnt_nxt_s;
  logic          rd_done_s;

  logic          rden_r, rden_nxt_s;
  logic          wren_r, wren_nxt_s;
  logic [AW-1:0] reg_addr_r, reg_addr_nxt_s;
  logic [31:0]   reg_wdata_r, reg_wdata_nxt_s;
  logic          rsp_valid_r, rsp_valid_nxt_s;
  logic [31:0]   rsp_rdata_r, rsp_rdata_nxt_s;
  logic          rsp_err_r, rsp_err_nxt_s;

  // Next-state and next-output decode; bus outputs are registered from these.
  always_comb begin
    state_nxt_s     = state_r;
    op_nxt_s        = op_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    mask_nxt_s      = mask_r;
    rd_nxt_s        = rd_r;
    cnt_nxt_s       = cnt_r;
    rd_done_s       = 1'b0;
    rden_nxt_s      = 1'b0;
    wren_nxt_s      = 1'b0;
    reg_addr_nxt_s  = reg_addr_r;
    reg_wdata_nxt_s = reg_wdata_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_err_nxt_s   = rsp_err_r;

    case (state_r)
      IDLE: begin
        if (cmd_valid_i) begin
          op_nxt_s    = cmd_op_i;
          addr_nxt_s  = cmd_addr_i;
          wdata_nxt_s = cmd_wdata_i;
          mask_nxt_s  = cmd_mask_i;
          case (cmd_op_i)
            OP_READ, OP_RMW: begin
              state_nxt_s    = RD;
              rden_nxt_s     = 1'b1;
              reg_addr_nxt_s = cmd_addr_i;
            end
            OP_WRITE: begin
              state_nxt_s     = WR;
              wren_nxt_s      = 1'b1;
              reg_addr_nxt_s  = cmd_addr_i;
              reg_wdata_nxt_s = cmd_wdata_i;
            end
            default: begin
              state_nxt_s     = RSP;
              rsp_valid_nxt_s = 1'b1;
              rsp_rdata_nxt_s = 32'h0000_0000;
              rsp_err_nxt_s   = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (RD_LAT == 0) begin
          rd_done_s = 1'b1;
        end else begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = LAT_M1;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 3'd0) begin
          rd_done_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      WR: begin
        state_nxt_s     = RSP;
        rsp_valid_nxt_s = 1'b1;
        rsp_rdata_nxt_s = (op_r == OP_RMW) ? rd_r : 32'h0000_0000;
        rsp_err_nxt_s   = 1'b0;
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_nxt_s     = IDLE;
          rsp_valid_nxt_s = 1'b0;
          rsp_rdata_nxt_s = 32'h0000_0000;
          rsp_err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = RSP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Read data is sampled in the same cycle the read phase completes.
    if (rd_done_s) begin
      rd_nxt_s = reg_rdata_i;
      if (op_r == OP_RMW) begin
        state_nxt_s     = WR;
        wren_nxt_s      = 1'b1;
        reg_addr_nxt_s  = addr_r;
        reg_wdata_nxt_s = rmw_merge(reg_rdata_i, wdata_r, mask_r);
      end else begin
        state_nxt_s     = RSP;
        rsp_valid_nxt_s = 1'b1;
        rsp_rdata_nxt_s = reg_rdata_i;
        rsp_err_nxt_s   = 1'b0;
      end
    end else begin
      rd_nxt_s = rd_r;
    end
  end

  // State, captured command and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 2'b00;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= 32'h0000_0000;
      mask_r      <= 32'h0000_0000;
      rd_r        <= 32'h0000_0000;
      cnt_r       <= 3'd0;
      rden_r      <= 1'b0;
      wren_r      <= 1'b0;
      reg_addr_r  <= {AW{1'b0}};
      reg_wdata_r <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      mask_r      <= mask_nxt_s;
      rd_r        <= rd_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rden_r      <= rden_nxt_s;
      wren_r      <= wren_nxt_s;
      reg_addr_r  <= reg_addr_nxt_s;
      reg_wdata_r <= reg_wdata_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
    end
  end

  // Ready is gated by rst_n so it drops immediately when reset is asserted.
  assign cmd_ready_o = (state_r == IDLE) && rst_n;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign reg_addr_o  = reg_addr_r;
  assign reg_wren_o  = wren_r;
  assign reg_rden_o  = rden_r;
  assign reg_wdata_o = reg_wdata_r;

endmodule

// File: tb/tb_cfg_reg_initiator.sv
// Directed bench for cfg_reg_initiator: one instance with RD_LAT=0 and one with RD_LAT=3,
// each attached to a simple register-file slave.
module tb_cfg_reg_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;

  logic        ready0, rv0, er0, wren0, rden0;
  logic [31:0] rdat0, wd0, sd0;
  logic [3:0]  ra0;
  logic        ready3, rv3, er3, wren3, rden3;
  logic [31:0] rdat3, wd3, sd3;
  logic [3:0]  ra3;
  logic [31:0] mem0 [16];
  logic [31:0] mem3 [16];

  logic        cmd_ready, rsp_valid, rsp_err, reg_wren, reg_rden;
  logic [31:0] rsp_rdata, reg_wdata;
  logic [3:0]  reg_addr;

  always #5 clk = ~clk;

  cfg_reg_initiator #(.AW(4), .RD_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(ready0),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdat0), .rsp_err_o(er0),
    .reg_addr_o(ra0), .reg_wren_o(wren0), .reg_rden_o(rden0), .reg_wdata_o(wd0),
    .reg_rdata_i(sd0)
  );

  cfg_reg_initiator #(.AW(4), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(ready3),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdat3), .rsp_err_o(er3),
    .reg_addr_o(ra3), .reg_wren_o(wren3), .reg_rden_o(rden3), .reg_wdata_o(wd3),
    .reg_rdata_i(sd3)
  );

  // Register-file slaves: data follows the held bus address, so any read latency sees it.
  always @(posedge clk) begin
    if (wren0) mem0[ra0] <= wd0;
    if (wren3) mem3[ra3] <= wd3;
  end
  assign sd0 = mem0[ra0];
  assign sd3 = mem3[ra3];

  assign cmd_ready = sel ? ready3 : ready0;
  assign rsp_valid = sel ? rv3    : rv0;
  assign rsp_rdata = sel ? rdat3  : rdat0;
  assign rsp_err   = sel ? er3    : er0;
  assign reg_wren  = sel ? wren3  : wren0;
  assign reg_rden  = sel ? rden3  : rden0;
  assign reg_wdata = sel ? wd3    : wd0;
  assign reg_addr  = sel ? ra3    : ra0;

  // Present one command; returns at the negedge of cycle T+1 with the inputs scrambled.
  task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [31:0] mask);
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mask; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = 4'hF;
    cmd_wdata = 32'h0BAD_0BAD; cmd_mask = 32'hFFFF_FFFF;
  endtask

  // Observe from cycle T+1 until the response appears (bounded); k counts cycles after T.
  task automatic watch(output int rden_at, output int wren_at, output int rsp_at,
                       output int nr, output int nw, output int both,
                       output logic [31:0] wd, output logic [3:0] wa,
                       output logic [31:0] rd, output logic er);
    rden_at = -1; wren_at = -1; rsp_at = -1; nr = 0; nw = 0; both = 0;
    wd = 32'h0; wa = 4'h0; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (reg_rden && reg_wren) both++;
      if (reg_rden) begin
        nr++;
        if (rden_at < 0) rden_at = k;
      end
      if (reg_wren) begin
        nw++;
        if (wren_at < 0) begin wren_at = k; wd = reg_wdata; wa = reg_addr; end
      end
      if (rsp_valid) begin
        rsp_at = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = 2'b00; cmd_addr = 4'h0; cmd_wdata = 32'h0; cmd_mask = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready0, ready3} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {ready0, ready3});
    end
    checks++;
    if ({rv0, er0, wren0, rden0, rv3, er3, wren3, rden3} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %h want 00", {rv0, er0, wren0, rden0, rv3, er3, wren3, rden3});
    end
    checks++;
    if ({rdat0, wd0, ra0} !== 68'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {rdat0, wd0, ra0});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ready0, ready3} !== 2'b11) begin
      errors++; $display("FAIL release_ready: got %b want 11", {ready0, ready3});
    end
    // Idle with no valid: ready stays high, nothing moves.
    repeat (3) @(negedge clk);
    checks++;
    if ({ready0, ready3, rv0, wren0, rden0} !== 5'b11000) begin
      errors++; $display("FAIL idle_quiet: got %b want 11000", {ready0, ready3, rv0, wren0, rden0});
    end
  endtask

  task automatic test_write;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    sel = 1'b0;
    issue(2'b01, 4'h2, 32'hDEAD_BEEF, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (wa != 1 || nw != 1 || nr != 0) begin
      errors++; $display("FAIL write_strobe: wren_at %0d nw %0d nr %0d want 1 1 0", wa, nw, nr);
    end
    checks++;
    if (wd !== 32'hDEAD_BEEF || ad !== 4'h2) begin
      errors++; $display("FAIL write_bus: got %h@%h want deadbeef@2", wd, ad);
    end
    checks++;
    if (sa != 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL write_rsp: at %0d err %b rdata %h want 2 0 0", sa, er, rd);
    end
  endtask

  task automatic test_read;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    sel = 1'b0;
    issue(2'b00, 4'h2, 32'h0, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (ra != 1 || nr != 1 || nw != 0) begin
      errors++; $display("FAIL read_strobe: rden_at %0d nr %0d nw %0d want 1 1 0", ra, nr, nw);
    end
    checks++;
    if (sa != 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL read_rsp: at %0d rdata %h err %b want 2 deadbeef 0", sa, rd, er);
    end
  endtask

  task automatic test_rmw_lat3;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    sel = 1'b1;
    issue(2'b01, 4'h5, 32'hFFFF_0000, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (wa != 1 || sa != 2) begin
      errors++; $display("FAIL lat3_write: wren_at %0d rsp_at %0d want 1 2", wa, sa);
    end
    issue(2'b10, 4'h5, 32'h0000_ABCD, 32'h0000_FFFF);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (ra != 1 || wa != 5 || sa != 6 || both != 0) begin
      errors++; $display("FAIL rmw_timing: rden %0d wren %0d rsp %0d both %0d want 1 5 6 0", ra, wa, sa, both);
    end
    checks++;
    if (wd !== 32'hFFFF_ABCD || ad !== 4'h5) begin
      errors++; $display("FAIL rmw_wdata: got %h@%h want ffffabcd@5", wd, ad);
    end
    checks++;
    if (rd !== 32'hFFFF_0000 || er !== 1'b0) begin
      errors++; $display("FAIL rmw_rsp: rdata %h err %b want ffff0000 0", rd, er);
    end
    issue(2'b00, 4'h5, 32'h0, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (ra != 1 || sa != 5 || rd !== 32'hFFFF_ABCD) begin
      errors++; $display("FAIL lat3_read: rden %0d rsp %0d rdata %h want 1 5 ffffabcd", ra, sa, rd);
    end
  endtask

  task automatic test_reserved;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    sel = 1'b0;
    issue(2'b11, 4'h2, 32'h1234_5678, 32'hFFFF_FFFF);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (sa != 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL rsvd_rsp: at %0d err %b rdata %h want 1 1 0", sa, er, rd);
    end
    @(negedge clk);
    checks++;
    if (nr != 0 || nw != 0 || reg_rden !== 1'b0 || reg_wren !== 1'b0) begin
      errors++; $display("FAIL rsvd_strobes: nr %0d nw %0d want 0 0", nr, nw);
    end
  endtask

  task automatic test_stall;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    int bad;
    sel = 1'b0; rsp_ready = 1'b0;
    issue(2'b00, 4'h2, 32'h0, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (sa != 2 || rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL stall_first: at %0d rdata %h want 2 deadbeef", sa, rd);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || cmd_ready !== 1'b0 ||
          reg_rden !== 1'b0 || reg_wren !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold: %0d bad cycles want 0", bad);
    end
    // Handshake cycle H: a command offered now must not be taken.
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_op = 2'b01; cmd_addr = 4'h7; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hs: ready %b valid %b want 0 1", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL next_accept: ready %b valid %b want 1 0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (wa != 1 || sa != 2 || wd !== 32'h1234_5678 || ad !== 4'h7) begin
      errors++; $display("FAIL next_write: wren %0d rsp %0d data %h@%h want 1 2 12345678@7", wa, sa, wd, ad);
    end
  endtask

  task automatic test_reset_mid;
    int ra, wa, sa, nr, nw, both; logic [31:0] wd, rd; logic [3:0] ad; logic er;
    int bad;
    sel = 1'b1;
    issue(2'b10, 4'h5, 32'h0000_0000, 32'hFFFF_FFFF);
    checks++;
    if (reg_rden !== 1'b1) begin
      errors++; $display("FAIL mid_rden: got %b want 1", reg_rden);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready: got %b want 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, reg_wren, reg_rden} !== 4'b0000 || {rsp_rdata, reg_wdata, reg_addr} !== 68'h0) begin
      errors++; $display("FAIL mid_outputs: got %b %h want 0000 0",
                         {rsp_valid, rsp_err, reg_wren, reg_rden}, {rsp_rdata, reg_wdata, reg_addr});
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (reg_wren !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_abandon: %0d active cycles want 0", bad);
    end
    issue(2'b01, 4'h1, 32'hA5A5_5A5A, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (wa != 1 || sa != 2 || wd !== 32'hA5A5_5A5A || er !== 1'b0) begin
      errors++; $display("FAIL post_write: wren %0d rsp %0d data %h err %b want 1 2 a5a55a5a 0", wa, sa, wd, er);
    end
    issue(2'b00, 4'h5, 32'h0, 32'h0);
    watch(ra, wa, sa, nr, nw, both, wd, ad, rd, er);
    checks++;
    if (sa != 5 || rd !== 32'hFFFF_ABCD) begin
      errors++; $display("FAIL mid_nowrite: rsp %0d rdata %h want 5 ffffabcd", sa, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rmw_lat3();
    test_reserved();
    test_stall();
    test_reset_mid();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cfg_reg_initiator.md
Name: cfg_reg_initiator

Overview:
- Command-driven initiator for the DMAC configuration-register bus; the requester side of the wren/rden/wdata/rdata register interface.
- Accepts READ, WRITE and read-modify-write (RMW) commands over a valid/ready channel.
- Sequences the register-bus strobes and returns one response per command over a valid/ready channel.
- Sits between the host-side bus adapter and the DMAC configuration registers.

Parameters:
- AW, 4, register address width.
- RD_LAT, 0, cycles between rden_o assertion and rdata_i sampling; legal range 0..7.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command ready.
- cmd_op_i  input  2  00=READ, 01=WRITE, 10=RMW, 11=reserved.
- cmd_addr_i  input  AW  register address.
- cmd_wdata_i  input  32  write data.
- cmd_mask_i  input  32  RMW bit mask (1 = take bit from cmd_wdata_i).
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response ready.
- rsp_rdata_o  output  32  read data (old value for RMW; 0 for WRITE/error).
- rsp_err_o  output  1  reserved-opcode error.
- reg_addr_o  output  AW  register-bus address.
- reg_wren_o  output  1  register write enable (1-cycle pulse).
- reg_rden_o  output  1  register read enable (1-cycle pulse).
- reg_wdata_o  output  32  register write data.
- reg_rdata_i  input  32  register read data.

Behaviour:
- Clock clk; reset rst_n is synchronous and active-low.
- Reset: state IDLE; all registered outputs 0; cmd_ready_o forced 0 while rst_n=0.
- Reset mid-operation: command abandoned, strobes low at the next edge, no response produced.
- Accept: handshake when cmd_valid_i && cmd_ready_o (cycle T). cmd_ready_o=1 only in IDLE with rst_n=1.
- Capture: op, addr, wdata and mask are captured at T; later input changes are ignored.
- States: IDLE, RD, RD_WAIT, WR, RSP.
- IDLE -> RD on READ/RMW, WR on WRITE, RSP on reserved.
- RD: one cycle; reg_rden_o=1, reg_addr_o=captured addr. RD_LAT=0 samples reg_rdata_i in this cycle, else -> RD_WAIT.
- RD_WAIT: down-counter loaded with RD_LAT-1; reg_rdata_i sampled when the counter reaches 0. Rdata is sampled exactly RD_LAT cycles after the rden cycle.
- After the read: READ -> RSP; RMW -> WR.
- WR: one cycle; reg_wren_o=1, reg_addr_o=addr.
  - WRITE: reg_wdata_o = wdata.
  - RMW: reg_wdata_o = (rd & ~mask) | (wdata & mask).
  - WR -> RSP.
- RSP: rsp_valid_o=1 and the response is held stable until rsp_ready_i=1; then -> IDLE. There is no RSP->IDLE bypass, so the next command is accepted one cycle after the response handshake at the earliest.
- Timing, L=RD_LAT:
  - WRITE: wren at T+1, rsp_valid at T+2.
  - READ: rden at T+1, rsp_valid at T+2+L.
  - RMW: rden at T+1, wren at T+2+L, rsp_valid at T+3+L.
  - Reserved: rsp_valid at T+1, rsp_err_o=1, rsp_rdata_o=0, no bus strobes.
- Strobes: reg_rden_o and reg_wren_o are never high in the same cycle. Outside RD/WR, reg_wdata_o and reg_addr_o keep their last values and both strobes are 0.
- Errors: rsp_err_o=0 for all legal opcodes.
- Response stall: rsp_ready_i=0 holds RSP indefinitely. cmd_ready_o stays 0 and no bus activity occurs.
- Idle ready: cmd_valid_i low in IDLE keeps cmd_ready_o=1 with no side effects.

Test Plan:
- RD_LAT=0, reset, WRITE addr=2 wdata=0xDEADBEEF -> wren pulse at T+1 with data 0xDEADBEEF; rsp_valid at T+2, err=0, rdata=0.
- Same slave, READ addr=2 -> rden at T+1; rsp_valid at T+2 with rdata 0xDEADBEEF.
- RD_LAT=3 model, slave holds 0xFFFF0000, RMW wdata=0x0000ABCD mask=0x0000FFFF -> rden T+1, wren T+5 with 0xFFFFABCD; rsp at T+6 with rdata 0xFFFF0000.
- op=11 -> rsp_valid at T+1, err=1, rdata=0; no wren/rden ever asserted.
- READ with rsp_ready_i held 0 for 10 cycles -> rsp_valid and rdata stable, cmd_ready_o=0 throughout. Next cmd accepted exactly 1 cycle after the handshake.
- rst_n pulled low during RD_WAIT of an RMW -> no wren, no response; all outputs 0 after the edge. A new WRITE after release completes normally.
